// File: rtl/sum_accum_nbit_pkg.sv
// Shared constants for the block-sum stage: FSM encoding, accumulator sizing, block counter width.
package sum_accum_nbit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int BLOCKS_W = 8;

  // Width that holds COUNT maximal (N+1)-bit sums without overflow.
  function automatic int acc_width(input int n, input int count);
    return n + 1 + $clog2(count);
  endfunction

endpackage

// File: rtl/sum_accum_nbit.sv
// Accumulates COUNT consecutive adder sums into one total, handed off over valid/ready.
// Optional averaged output enabled by defining SUM_ACCUM_AVG_EN.
module sum_accum_nbit
  import sum_accum_nbit_pkg::*;
#(
  parameter int N     = 10,
  parameter int COUNT = 4,
  parameter int ACC_W = acc_width(N, COUNT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N:0]          in_sum,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    out_acc,
  output logic [BLOCKS_W-1:0] out_blocks
`ifdef SUM_ACCUM_AVG_EN
  ,
  output logic [N:0]          out_avg
`endif
);

  localparam int CNT_W = $clog2(COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  if (COUNT < 2) begin : g_count_chk
    $error("sum_accum_nbit: COUNT must be 2 or more");
  end

`ifdef SUM_ACCUM_AVG_EN
  if ((COUNT & (COUNT - 1)) != 0) begin : g_pow2_chk
    $error("sum_accum_nbit: COUNT must be a power of two when averaging");
  end

  function automatic logic [N:0] avg_of(input logic [ACC_W-1:0] total);
    return (N+1)'(total >> CNT_W);
  endfunction
`endif

  state_t           state_p0;
  logic [ACC_W-1:0] acc_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             accept;
  logic [ACC_W-1:0] acc_nxt;

  assign accept  = in_valid && in_ready;
  assign acc_nxt = acc_p0 + ACC_W'(in_sum);

  // Stage p0 -> output: FSM, accumulator and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0   <= ST_IDLE;
      acc_p0     <= '0;
      cnt_p0     <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_acc    <= '0;
      out_blocks <= '0;
`ifdef SUM_ACCUM_AVG_EN
      out_avg    <= '0;
`endif
    end else begin
      case (state_p0)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            if (state_p0 == ST_ACCUM && cnt_p0 == CNT_LAST) begin
              out_acc   <= acc_nxt;
`ifdef SUM_ACCUM_AVG_EN
              out_avg   <= avg_of(acc_nxt);
`endif
              acc_p0    <= '0;
              cnt_p0    <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state_p0  <= ST_HOLD;
            end else begin
              acc_p0   <= acc_nxt;
              cnt_p0   <= cnt_p0 + 1'b1;
              state_p0 <= ST_ACCUM;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            out_blocks <= out_blocks + 1'b1;
            state_p0   <= ST_IDLE;
          end
        end
        default: begin
          acc_p0    <= '0;
          cnt_p0    <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state_p0  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accum_nbit.sv
// Directed bench for sum_accum_nbit (N=10, COUNT=4); checks out_avg when SUM_ACCUM_AVG_EN is defined.
module tb_sum_accum_nbit;

  localparam int N     = 10;
  localparam int COUNT = 4;
  localparam int ACC_W = 13;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [N:0]       in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [7:0]       out_blocks;
`ifdef SUM_ACCUM_AVG_EN
  logic [N:0]       out_avg;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sum_accum_nbit #(.N(N), .COUNT(COUNT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_blocks(out_blocks)
`ifdef SUM_ACCUM_AVG_EN
    ,
    .out_avg   (out_avg)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [N:0] v);
    in_valid = 1'b1;
    in_sum   = v;
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_acc", 32'(out_acc), 0);
    chk("rst_out_blocks", 32'(out_blocks), 0);
    reset = 1'b0;

    // 1: basic block 0+100+99+147
    out_ready = 1'b1;
    send(11'd0);
    send(11'd100);
    send(11'd99);
    chk("t1_not_yet_valid", 32'(out_valid), 0);
    send(11'd147);
    chk("t1_out_valid", 32'(out_valid), 1);
    chk("t1_out_acc", 32'(out_acc), 346);
    chk("t1_in_ready_hold", 32'(in_ready), 0);
`ifdef SUM_ACCUM_AVG_EN
    chk("t1_out_avg", 32'(out_avg), 86);
`endif
    in_valid = 1'b0;
    tick();
    chk("t1_out_valid_drop", 32'(out_valid), 0);
    chk("t1_out_blocks", 32'(out_blocks), 1);
    chk("t1_in_ready_back", 32'(in_ready), 1);

    // 2: maximum sums
    for (int i = 0; i < 4; i++) send(11'd2046);
    chk("t2_out_valid", 32'(out_valid), 1);
    chk("t2_out_acc_max", 32'(out_acc), 8184);
`ifdef SUM_ACCUM_AVG_EN
    chk("t2_out_avg", 32'(out_avg), 2046);
`endif
    in_valid = 1'b0;
    tick();
    chk("t2_out_blocks", 32'(out_blocks), 2);

    // 3: backpressure in HOLD with in_valid held high
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(11'd5);
    in_sum = 11'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_in_ready_low", 32'(in_ready), 0);
      chk("t3_out_valid_held", 32'(out_valid), 1);
      chk("t3_out_acc_held", 32'(out_acc), 20);
    end
    chk("t3_blocks_stalled", 32'(out_blocks), 2);
    out_ready = 1'b1;
    tick();
    chk("t3_release_valid", 32'(out_valid), 0);
    chk("t3_release_ready", 32'(in_ready), 1);
    chk("t3_release_blocks", 32'(out_blocks), 3);
    for (int i = 0; i < 4; i++) send(11'd7);
    chk("t3_resume_valid", 32'(out_valid), 1);
    chk("t3_resume_acc", 32'(out_acc), 28);
    in_valid = 1'b0;
    tick();
    chk("t3_resume_blocks", 32'(out_blocks), 4);

    // 4: gaps in in_valid
    in_sum = 11'd10;
    in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    tick();
    in_valid = 1'b1; tick();
    tick();
    in_valid = 1'b0; tick();
    chk("t4_gap_not_valid", 32'(out_valid), 0);
    in_valid = 1'b1; tick();
    chk("t4_out_valid", 32'(out_valid), 1);
    chk("t4_out_acc", 32'(out_acc), 40);
    in_valid = 1'b0;
    tick();
    chk("t4_out_blocks", 32'(out_blocks), 5);

    // 5: reset mid-block discards the partial sum
    send(11'd33);
    send(11'd66);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("t5_rst_blocks", 32'(out_blocks), 0);
    chk("t5_rst_acc", 32'(out_acc), 0);
    chk("t5_rst_valid", 32'(out_valid), 0);
    chk("t5_rst_ready", 32'(in_ready), 1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) send(11'd1);
    chk("t5_out_valid", 32'(out_valid), 1);
    chk("t5_out_acc", 32'(out_acc), 4);
    in_valid = 1'b0;
    tick();
    chk("t5_out_blocks", 32'(out_blocks), 1);

    // 6: 256 back-to-back blocks, five cycles each
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b1;
    in_sum   = 11'd3;
    for (int i = 0; i < 5 * 255; i++) tick();
    chk("t6_blocks_255", 32'(out_blocks), 255);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_blocks_wrap", 32'(out_blocks), 0);
    chk("t6_last_acc", 32'(out_acc), 12);
    chk("t6_valid_low", 32'(out_valid), 0);
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
